// File: rtl/motor_mixer.sv
// Quad-X motor mixer: turns throttle plus yaw/roll/pitch rate commands into
// four clamped motor commands. One command set in flight at a time; the
// FSM walks IDLE -> SCALE -> SUM -> SAT -> DONE, one register stage per state.
module motor_mixer #(
    parameter int N_RATE     = 36,
    parameter int RATE_SHIFT = 16,
    parameter int N_MOTOR    = 8,
    parameter int MOTOR_MIN  = 16,
    parameter int MOTOR_MAX  = 250
) (
    input  logic                     sys_clk,
    input  logic                     resetn,
    input  logic signed [N_RATE-1:0] yaw_rate,
    input  logic signed [N_RATE-1:0] roll_rate,
    input  logic signed [N_RATE-1:0] pitch_rate,
    input  logic [N_MOTOR-1:0]       throttle,
    input  logic                     armed,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [N_MOTOR-1:0]       motor_fl,
    output logic [N_MOTOR-1:0]       motor_fr,
    output logic [N_MOTOR-1:0]       motor_rl,
    output logic [N_MOTOR-1:0]       motor_rr,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Three extra bits cover the sum of throttle and three full-range terms.
    localparam int SW = N_RATE + 3;
    localparam logic signed [SW-1:0] MIN_S = SW'(MOTOR_MIN);
    localparam logic signed [SW-1:0] MAX_S = SW'(MOTOR_MAX);

    typedef enum logic [2:0] {IDLE, SCALE, SUM, SAT, DONE} state_t;

    state_t state, state_nx;

    logic signed [N_RATE-1:0] yaw_q, roll_q, pitch_q;
    logic signed [N_RATE-1:0] y_t, r_t, p_t;
    logic [N_MOTOR-1:0]       thr_q;
    logic                     armed_q;
    logic signed [SW-1:0]     t_x, y_x, r_x, p_x;
    logic signed [SW-1:0]     fl_s, fr_s, rl_s, rr_s;

    function automatic logic [N_MOTOR-1:0] clamp(input logic signed [SW-1:0] s);
        if (s < MIN_S)
            clamp = N_MOTOR'(MOTOR_MIN);
        else if (s > MAX_S)
            clamp = N_MOTOR'(MOTOR_MAX);
        else
            clamp = s[N_MOTOR-1:0];
    endfunction

    // Throttle is unsigned (zero-extend); rate terms are signed (sign-extend).
    assign t_x = $signed({{(SW-N_MOTOR){1'b0}}, thr_q});
    assign y_x = $signed({{3{y_t[N_RATE-1]}}, y_t});
    assign r_x = $signed({{3{r_t[N_RATE-1]}}, r_t});
    assign p_x = $signed({{3{p_t[N_RATE-1]}}, p_t});

    // State register.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and handshake outputs; DONE waits for the consumer.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SCALE;
            end
            SCALE: state_nx = SUM;
            SUM:   state_nx = SAT;
            SAT:   state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: each state advances the in-flight set by one stage.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            yaw_q    <= '0;
            roll_q   <= '0;
            pitch_q  <= '0;
            thr_q    <= '0;
            armed_q  <= 1'b0;
            y_t      <= '0;
            r_t      <= '0;
            p_t      <= '0;
            fl_s     <= '0;
            fr_s     <= '0;
            rl_s     <= '0;
            rr_s     <= '0;
            motor_fl <= '0;
            motor_fr <= '0;
            motor_rl <= '0;
            motor_rr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        yaw_q   <= yaw_rate;
                        roll_q  <= roll_rate;
                        pitch_q <= pitch_rate;
                        thr_q   <= throttle;
                        armed_q <= armed;
                    end
                end
                SCALE: begin
                    // Arithmetic shift floors, so tiny negative rates give -1.
                    y_t <= yaw_q >>> RATE_SHIFT;
                    r_t <= roll_q >>> RATE_SHIFT;
                    p_t <= pitch_q >>> RATE_SHIFT;
                end
                SUM: begin
                    fl_s <= t_x + p_x + r_x - y_x;
                    fr_s <= t_x + p_x - r_x + y_x;
                    rl_s <= t_x - p_x + r_x + y_x;
                    rr_s <= t_x - p_x - r_x - y_x;
                end
                SAT: begin
                    motor_fl <= armed_q ? clamp(fl_s) : '0;
                    motor_fr <= armed_q ? clamp(fr_s) : '0;
                    motor_rl <= armed_q ? clamp(rl_s) : '0;
                    motor_rr <= armed_q ? clamp(rr_s) : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_mixer.sv
// Directed bench for motor_mixer: mixing, clamping, disarm, backpressure,
// back-to-back throughput and asynchronous reset mid-operation.
module tb_motor_mixer;

    logic               sys_clk;
    logic               resetn;
    logic signed [35:0] yaw_rate, roll_rate, pitch_rate;
    logic [7:0]         throttle;
    logic               armed;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         motor_fl, motor_fr, motor_rl, motor_rr;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    motor_mixer dut (
        .sys_clk   (sys_clk),
        .resetn    (resetn),
        .yaw_rate  (yaw_rate),
        .roll_rate (roll_rate),
        .pitch_rate(pitch_rate),
        .throttle  (throttle),
        .armed     (armed),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .motor_fl  (motor_fl),
        .motor_fr  (motor_fr),
        .motor_rl  (motor_rl),
        .motor_rr  (motor_rr),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    // Present one set for exactly one rising edge; returns at the following negedge.
    task automatic send(input logic signed [35:0] y, input logic signed [35:0] r,
                        input logic signed [35:0] p, input logic [7:0] t, input logic a);
        @(negedge sys_clk);
        yaw_rate = y; roll_rate = r; pitch_rate = p; throttle = t; armed = a;
        in_valid = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    // Counts edges from the accepting edge (=1) until out_valid is seen; bounded.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
        end
    endtask

    // Accept the pending result with a one-cycle out_ready pulse.
    task automatic drain();
        @(negedge sys_clk);
        out_ready = 1'b1;
        @(negedge sys_clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        checks++;
        if ({motor_fl, motor_fr, motor_rl, motor_rr} !== 32'h0) begin
            errors++; $display("FAIL reset_motors got %h exp 00000000", {motor_fl, motor_fr, motor_rl, motor_rr});
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_hs got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
        @(negedge sys_clk);
        resetn = 1'b1;
    endtask

    task automatic test_hover();
        int cyc;
        send(0, 0, 0, 8'd100, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4) begin
            errors++; $display("FAIL hover_latency got %0d exp 4", cyc);
        end
        checks++;
        if ({motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd100, 8'd100, 8'd100, 8'd100}) begin
            errors++; $display("FAIL hover_motors got %h exp 64646464", {motor_fl, motor_fr, motor_rl, motor_rr});
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hover_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_pitch();
        int cyc;
        send(0, 0, 36'sd655360, 8'd100, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd110, 8'd110, 8'd90, 8'd90}) begin
            errors++; $display("FAIL pitch got cyc=%0d %0d %0d %0d %0d exp cyc=4 110 110 90 90",
                               cyc, motor_fl, motor_fr, motor_rl, motor_rr);
        end
        drain();
    endtask

    task automatic test_high_clamp();
        int cyc;
        send(0, 36'sd1310720, 0, 8'd245, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd250, 8'd225, 8'd250, 8'd225}) begin
            errors++; $display("FAIL high_clamp got cyc=%0d %0d %0d %0d %0d exp cyc=4 250 225 250 225",
                               cyc, motor_fl, motor_fr, motor_rl, motor_rr);
        end
        drain();
    endtask

    task automatic test_low_clamp();
        int cyc;
        send(36'sd655360, 0, 0, 8'd20, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd16, 8'd30, 8'd30, 8'd16}) begin
            errors++; $display("FAIL low_clamp got cyc=%0d %0d %0d %0d %0d exp cyc=4 16 30 30 16",
                               cyc, motor_fl, motor_fr, motor_rl, motor_rr);
        end
        drain();
        // Raw -1 floors to a term of -1, not 0.
        send(-36'sd1, 0, 0, 8'd20, 1'b1);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd21, 8'd19, 8'd19, 8'd21}) begin
            errors++; $display("FAIL neg_one got cyc=%0d %0d %0d %0d %0d exp cyc=4 21 19 19 21",
                               cyc, motor_fl, motor_fr, motor_rl, motor_rr);
        end
        drain();
    endtask

    task automatic test_armed_latch();
        int cyc;
        send(0, 0, 0, 8'd80, 1'b1);
        armed = 1'b0;   // drops while in flight; must not affect the result
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd80, 8'd80, 8'd80, 8'd80}) begin
            errors++; $display("FAIL armed_latch got cyc=%0d %h exp cyc=4 50505050",
                               cyc, {motor_fl, motor_fr, motor_rl, motor_rr});
        end
        drain();
    endtask

    task automatic test_disarm_backpressure();
        int cyc;
        int bad;
        send(0, 0, 0, 8'd200, 1'b0);
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== 32'h0) begin
            errors++; $display("FAIL disarm got cyc=%0d %h exp cyc=4 00000000",
                               cyc, {motor_fl, motor_fr, motor_rl, motor_rr});
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                throttle = 8'd50; armed = 1'b1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge sys_clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {motor_fl, motor_fr, motor_rl, motor_rr} !== 32'h0)
                bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL backpressure_hold got %0d bad cycles exp 0", bad);
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
        end
        // A set pulsed during DONE must not have been latched: block stays idle.
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (in_ready !== 1'b1 || out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL ignored_in_valid got %0d busy cycles exp 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        int hits;
        @(negedge sys_clk);
        yaw_rate = 0; roll_rate = 0; pitch_rate = 0; throttle = 8'd40; armed = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        bad = 0; hits = 0;
        // First accept on the next edge; results every 5 cycles, never accepted in DONE.
        for (int i = 0; i < 15; i++) begin
            @(negedge sys_clk);
            if (out_valid !== ((i % 5) == 3)) bad++;
            if (out_valid === 1'b1) begin
                hits++;
                if ({motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd40, 8'd40, 8'd40, 8'd40}) bad++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (bad !== 0 || hits !== 3) begin
            errors++; $display("FAIL back_to_back got bad=%0d hits=%0d exp bad=0 hits=3", bad, hits);
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        send(0, 0, 0, 8'd100, 1'b1);
        wait_out(cyc);
        drain();
        checks++;
        if (motor_fl !== 8'd100 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_after_drop got fl=%0d ov=%b exp fl=100 ov=0", motor_fl, out_valid);
        end
        send(0, 0, 0, 8'd100, 1'b1);        // now in SCALE
        @(posedge sys_clk);                  // now in SUM
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({motor_fl, motor_fr, motor_rl, motor_rr} !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_op got %h ov=%b ir=%b exp 00000000 ov=0 ir=1",
                               {motor_fl, motor_fr, motor_rl, motor_rr}, out_valid, in_ready);
        end
        @(negedge sys_clk);
        resetn = 1'b1;
        send(0, 36'sd196608, 0, 8'd60, 1'b1);   // R = 3
        wait_out(cyc);
        checks++;
        if (cyc !== 4 || {motor_fl, motor_fr, motor_rl, motor_rr} !== {8'd63, 8'd57, 8'd63, 8'd57}) begin
            errors++; $display("FAIL after_reset got cyc=%0d %0d %0d %0d %0d exp cyc=4 63 57 63 57",
                               cyc, motor_fl, motor_fr, motor_rl, motor_rr);
        end
        drain();
    endtask

    initial begin
        yaw_rate = 0; roll_rate = 0; pitch_rate = 0; throttle = 0;
        armed = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_hover();
        test_pitch();
        test_high_clamp();
        test_low_clamp();
        test_armed_latch();
        test_disarm_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
